// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver and the packet deframer:
// deframer state encoding, default start-of-frame byte, and the
// bit-period helper used by both the receiver and the silence timer.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CHK     = 3'd3,
    ST_DRAIN   = 3'd4
  } uart_pkt_state_t;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

  // Clock cycles per UART bit period.
  function automatic int bit_period_cycles(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_pkt_buf.sv
// Payload buffer for the packet deframer: DEPTH x 8 register array,
// synchronous write port, combinational read port.
module uart_pkt_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [DEPTH];

  // Store one payload byte per write strobe.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_pkt_rx.sv
// Byte-to-packet deframer: parses SOF, LEN, payload[LEN], CHK from the
// UART byte strobe, buffers the payload and releases it on a valid/ready
// stream once the XOR checksum matches.
// Optional build macro: UART_PKT_TIMEOUT_EN compiles in the inter-byte
// silence timer; without it err_timeout is tied low.
//
// state      | meaning
// -----------+--------------------------------------------------------
// ST_IDLE    | hunting for SOF, other bytes ignored
// ST_LEN     | next byte is LEN
// ST_PAYLOAD | storing payload bytes, accumulating checksum
// ST_CHK     | next byte is the checksum
// ST_DRAIN   | presenting buffered payload on the output stream
module uart_pkt_rx
  import uart_pkg::*;
#(
  parameter logic [7:0] SOF           = SOF_DEFAULT,
  parameter int         MAX_LEN       = 16,
  parameter int         CLOCK_FREQ    = 50000000,
  parameter int         BAUD_RATE     = 9600,
  parameter int         TIMEOUT_BYTES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] pkt_data,
  output logic       pkt_valid,
  output logic       pkt_last,
  input  logic       pkt_ready,
  output logic [7:0] pkt_len,
  output logic       busy,
  output logic       err_chk,
  output logic       err_len,
  output logic       err_drop,
  output logic       err_timeout
);

  localparam int         PW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  uart_pkt_state_t r_state;
  logic [7:0]      r_len;
  logic [7:0]      r_acc;
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic            r_err_chk;
  logic            r_err_len;
  logic            r_err_drop;

  logic            w_we;
  logic [7:0]      w_rd_byte;
  logic [7:0]      w_wr_ptr_ext;
  logic [7:0]      w_rd_ptr_ext;
  logic            w_last;
  logic            w_xfer;
  logic            w_tmo_fire;

  assign w_wr_ptr_ext = 8'(r_wr_ptr);
  assign w_rd_ptr_ext = 8'(r_rd_ptr);
  assign w_we         = (r_state == ST_PAYLOAD) && rx_valid;
  assign w_last       = (r_state == ST_DRAIN) && (w_rd_ptr_ext == r_len - 8'd1);
  assign w_xfer       = pkt_valid && pkt_ready;

  uart_pkt_buf #(
    .DEPTH (MAX_LEN),
    .AW    (PW)
  ) u_buf (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (rx_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_byte)
  );

  // Frame parser and drain sequencer; error flags are single-cycle pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_len      <= 8'h00;
      r_acc      <= 8'h00;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_err_chk  <= 1'b0;
      r_err_len  <= 1'b0;
      r_err_drop <= 1'b0;
    end else begin
      r_err_chk  <= 1'b0;
      r_err_len  <= 1'b0;
      r_err_drop <= 1'b0;
      if (w_tmo_fire) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (rx_valid && (rx_data == SOF)) r_state <= ST_LEN;
          end
          ST_LEN: begin
            if (rx_valid) begin
              r_len <= rx_data;
              r_acc <= rx_data;
              if ((rx_data == 8'h00) || (rx_data > MAX_LEN_B)) begin
                r_err_len <= 1'b1;
                r_state   <= ST_IDLE;
              end else begin
                r_wr_ptr <= '0;
                r_state  <= ST_PAYLOAD;
              end
            end
          end
          ST_PAYLOAD: begin
            if (rx_valid) begin
              r_acc <= r_acc ^ rx_data;
              // Final byte leaves the pointer alone so it never wraps at LEN == MAX_LEN.
              if (w_wr_ptr_ext == r_len - 8'd1) r_state <= ST_CHK;
              else r_wr_ptr <= r_wr_ptr + 1'b1;
            end
          end
          ST_CHK: begin
            if (rx_valid) begin
              if (rx_data == r_acc) begin
                r_rd_ptr <= '0;
                r_state  <= ST_DRAIN;
              end else begin
                r_err_chk <= 1'b1;
                r_state   <= ST_IDLE;
              end
            end
          end
          ST_DRAIN: begin
            if (rx_valid) r_err_drop <= 1'b1;
            if (w_xfer) begin
              if (w_last) r_state <= ST_IDLE;
              else r_rd_ptr <= r_rd_ptr + 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef UART_PKT_TIMEOUT_EN
  localparam int TMO_T = TIMEOUT_BYTES * 10 * bit_period_cycles(CLOCK_FREQ, BAUD_RATE);
  localparam int TW    = $clog2(TMO_T + 1);

  logic [TW-1:0] r_tmo_cnt;
  logic          r_err_timeout;
  logic          w_tmo_active;

  assign w_tmo_active = (r_state == ST_LEN) || (r_state == ST_PAYLOAD) || (r_state == ST_CHK);
  // Loaded with T-2 so the pulse lands exactly T cycles after the strobe cycle.
  assign w_tmo_fire   = w_tmo_active && !rx_valid && (r_tmo_cnt == '0);

  // Silence down-counter: reloads on every byte, decrements only mid-frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmo_cnt     <= TW'(TMO_T - 2);
      r_err_timeout <= 1'b0;
    end else begin
      r_err_timeout <= w_tmo_fire;
      if (rx_valid) r_tmo_cnt <= TW'(TMO_T - 2);
      else if (w_tmo_active && (r_tmo_cnt != '0)) r_tmo_cnt <= r_tmo_cnt - 1'b1;
    end
  end

  assign err_timeout = r_err_timeout;
`else
  assign w_tmo_fire  = 1'b0;
  assign err_timeout = 1'b0;
`endif

  assign pkt_valid = (r_state == ST_DRAIN);
  assign pkt_data  = pkt_valid ? w_rd_byte : 8'h00;
  assign pkt_last  = w_last;
  assign pkt_len   = r_len;
  assign busy      = (r_state != ST_IDLE);
  assign err_chk   = r_err_chk;
  assign err_len   = r_err_len;
  assign err_drop  = r_err_drop;

endmodule
